// File: rtl/uart_pkg.sv
// Shared types and constants for the parametrised UART receiver.
// Optional 2-of-3 majority sampling is selected with UART_RX_MAJORITY_EN.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    DATA     = 3'd2,
    PARITY   = 3'd3,
    STOP     = 3'd4,
    BRK_WAIT = 3'd5
  } uart_state_e;

  localparam int ERR_FE = 0;
  localparam int ERR_PE = 1;
  localparam int ERR_BE = 2;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Two-flop rx synchroniser and per-bit sampler. With UART_RX_MAJORITY_EN the bit
// value is a 2-of-3 vote over three consecutive ticks around the bit centre.
module uart_rx_sampler #(
  parameter int OVS = 16,
  parameter int CW  = 4
) (
  input  logic          UART_clk,
  input  logic          rst,
  input  logic          sample_tick,
  input  logic          rx,
  input  logic [CW-1:0] tick_cnt,
  output logic          rx_sync,
  output logic          bit_val,
  output logic          bit_stb
);
  import uart_pkg::*;

  logic rx_meta;

  // Preset to 1 so reset looks like an idle line rather than a start bit.
  always_ff @(posedge UART_clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic samp_a;
  logic samp_b;

  always_ff @(posedge UART_clk or posedge rst) begin
    if (rst) begin
      samp_a <= 1'b1;
      samp_b <= 1'b1;
    end else if (sample_tick) begin
      if (tick_cnt == CW'(OVS/2 - 2)) samp_a <= rx_sync;
      if (tick_cnt == CW'(OVS/2 - 1)) samp_b <= rx_sync;
    end
  end

  // The vote resolves on the third sample tick, one tick after the single-sample point.
  assign bit_stb = sample_tick && (tick_cnt == CW'(OVS/2));
  assign bit_val = maj3(samp_a, samp_b, rx_sync);
`else
  assign bit_stb = sample_tick && (tick_cnt == CW'(OVS/2 - 1));
  assign bit_val = rx_sync;
`endif

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised oversampled UART receiver with a one-entry holding register and
// per-frame {BE, PE, FE} status. Majority sampling is enabled by UART_RX_MAJORITY_EN.
module uart_rx_param #(
  parameter int DATA_W    = 8,
  parameter int PARITY_EN = 1,
  parameter int ODD_nEVEN = 1,
  parameter int STOP_BITS = 1,
  parameter int OVS       = 16
) (
  input  logic              UART_clk,
  input  logic              rst,
  input  logic              sample_tick,
  input  logic              rx,
  output logic [DATA_W-1:0] rx_data,
  output logic [2:0]        rx_err,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              oe,
  output logic              busy,
  output logic [2:0]        dbg_state
);
  import uart_pkg::*;

  localparam int   CW       = $clog2(OVS);
  localparam int   BCW      = 4;
  localparam logic ODD_MODE = (ODD_nEVEN != 0) ? PAR_ODD : PAR_EVEN;

  uart_state_e       state;
  uart_state_e       state_nxt;
  logic [CW-1:0]     tick_cnt;
  logic [BCW-1:0]    bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic              par_s;
  logic              zero_acc;
  logic              fe_acc;
  logic              done_q;
  logic [2:0]        err_q;

  logic rx_s;
  logic bit_val;
  logic bit_stb;
  logic last_data;
  logic last_stop;
  logic be_now;
  logic fe_now;
  logic pe_now;
  logic frame_end;
  logic hs;

  uart_rx_sampler #(
    .OVS (OVS),
    .CW  (CW)
  ) u_sampler (
    .UART_clk    (UART_clk),
    .rst         (rst),
    .sample_tick (sample_tick),
    .rx          (rx),
    .tick_cnt    (tick_cnt),
    .rx_sync     (rx_s),
    .bit_val     (bit_val),
    .bit_stb     (bit_stb)
  );

  assign last_data = (bit_cnt == BCW'(DATA_W - 1));
  assign last_stop = (bit_cnt == BCW'(STOP_BITS - 1));
  assign be_now    = zero_acc && !bit_val;
  assign fe_now    = fe_acc || !bit_val;
  assign pe_now    = (PARITY_EN != 0) && (((^shreg) ^ par_s) != ODD_MODE);
  assign frame_end = (state == STOP) && bit_stb && last_stop;

  always_ff @(posedge UART_clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (sample_tick && !rx_s) state_nxt = START;
      START:    if (bit_stb) state_nxt = bit_val ? IDLE : DATA;
      DATA:     if (bit_stb && last_data) state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY:   if (bit_stb) state_nxt = STOP;
      STOP:     if (bit_stb && last_stop) state_nxt = be_now ? BRK_WAIT : IDLE;
      BRK_WAIT: if (sample_tick && rx_s) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    dbg_state = state;
  end

  // Tick counter is aligned to bit boundaries: the detecting tick is tick 0 of the start bit.
  always_ff @(posedge UART_clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_s    <= 1'b0;
      zero_acc <= 1'b0;
      fe_acc   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= '0;
    end else begin
      done_q <= frame_end;
      if (state == IDLE) begin
        tick_cnt <= (sample_tick && !rx_s) ? CW'(1) : '0;
        bit_cnt  <= '0;
      end else if (sample_tick) begin
        tick_cnt <= (tick_cnt == CW'(OVS - 1)) ? '0 : tick_cnt + CW'(1);
      end
      if (bit_stb) begin
        case (state)
          START: begin
            zero_acc <= 1'b1;
            fe_acc   <= 1'b0;
            bit_cnt  <= '0;
          end
          DATA: begin
            shreg    <= {bit_val, shreg[DATA_W-1:1]};
            zero_acc <= zero_acc && !bit_val;
            bit_cnt  <= last_data ? '0 : bit_cnt + BCW'(1);
          end
          PARITY: begin
            par_s    <= bit_val;
            zero_acc <= zero_acc && !bit_val;
          end
          STOP: begin
            zero_acc <= be_now;
            fe_acc   <= fe_now;
            bit_cnt  <= bit_cnt + BCW'(1);
            if (last_stop) begin
              err_q[ERR_FE] <= fe_now || be_now;
              err_q[ERR_PE] <= pe_now;
              err_q[ERR_BE] <= be_now;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Handshake: a frame transfers on any cycle where rx_valid && rx_ready; rx_data and
  // rx_err hold while rx_valid && !rx_ready. A frame finishing into a full register that
  // is not being drained that cycle is dropped and raises the sticky oe flag.
  assign hs = rx_valid && rx_ready;

  always_ff @(posedge UART_clk or posedge rst) begin
    if (rst) begin
      rx_data  <= '0;
      rx_err   <= '0;
      rx_valid <= 1'b0;
      oe       <= 1'b0;
    end else begin
      if (done_q && (!rx_valid || hs)) begin
        rx_data  <= shreg;
        rx_err   <= err_q;
        rx_valid <= 1'b1;
      end else if (hs) begin
        rx_valid <= 1'b0;
      end
      if (done_q && rx_valid && !hs) oe <= 1'b1;
      else if (hs)                   oe <= 1'b0;
    end
  end

endmodule
